// File: rtl/tick_req_if.sv
// tick_req_if: tick/ack inputs and request status outputs of the tick request generator
interface tick_req_if #(
    parameter int KBITS = 8,
    parameter int DBITS = 8
);
    logic             tick;
    logic             ack;
    logic             req;
    logic [7:0]       req_id;
    logic [KBITS-1:0] phase;
    logic             ovr;
    logic [DBITS-1:0] drops;
    modport master(output tick, ack, input req, req_id, phase, ovr, drops);
    modport slave(input tick, ack, output req, req_id, phase, ovr, drops);
endinterface

// File: rtl/tick_req_gen.sv
// tick_req_gen: issues one request every K ticks, flagging and counting firings dropped while a request is still pending
module tick_req_gen #(
    parameter int K     = 4,
    parameter int KBITS = 8,
    parameter int DBITS = 8
) (
    input logic        clk,
    input logic        rst,
    tick_req_if.slave  bus
);
    typedef enum logic {IDLE, WAIT} state_t;
    state_t           state;
    logic [7:0]       req_id;
    logic [KBITS-1:0] phase;
    logic             ovr;
    logic [DBITS-1:0] drops;
    logic             fire;
    assign fire = bus.tick && (phase == KBITS'(K - 1));
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            req_id <= '0;
            phase  <= '0;
            ovr    <= 1'b0;
            drops  <= '0;
        end else begin
            if (bus.tick)
                phase <= fire ? '0 : phase + 1'b1;
            if (fire) begin
                // an ack arriving with the fire frees the slot for the new request
                if (state == IDLE || bus.ack) begin
                    state  <= WAIT;
                    req_id <= req_id + 1'b1;
                end else begin
                    ovr   <= 1'b1;
                    drops <= (drops == {DBITS{1'b1}}) ? drops : drops + 1'b1;
                end
            end else if (state == WAIT && bus.ack) begin
                state <= IDLE;
            end
        end
    end
    assign bus.req    = (state == WAIT);
    assign bus.req_id = req_id;
    assign bus.phase  = phase;
    assign bus.ovr    = ovr;
    assign bus.drops  = drops;
endmodule

// File: tb/tb_tick_req_gen.sv
// tb_tick_req_gen: directed vector table plus saturation, reset and K=1 sequences
module tb_tick_req_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst1 = 1'b1;
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;

    tick_req_if #(.KBITS(8), .DBITS(8)) bus ();
    tick_req_if #(.KBITS(8), .DBITS(8)) bus1 ();

    tick_req_gen #(.K(4), .KBITS(8), .DBITS(8)) dut (.clk(clk), .rst(rst), .bus(bus));
    tick_req_gen #(.K(1), .KBITS(8), .DBITS(8)) dut1 (.clk(clk), .rst(rst1), .bus(bus1));

    typedef struct {
        logic       r, t, a;
        logic       req;
        logic [7:0] id, ph;
        logic       ovr;
        logic [7:0] drops;
    } vec_t;
    vec_t vecs[$];

    task automatic add(input logic r, t, a, q, input int id, ph, input logic o, input int d);
        vec_t v;
        v.r = r; v.t = t; v.a = a; v.req = q;
        v.id = 8'(id); v.ph = 8'(ph); v.ovr = o; v.drops = 8'(d);
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic q, input int id, ph, input logic o, input int d);
        check({tag, " req"}, int'(bus.req), int'(q));
        check({tag, " req_id"}, int'(bus.req_id), id);
        check({tag, " phase"}, int'(bus.phase), ph);
        check({tag, " ovr"}, int'(bus.ovr), int'(o));
        check({tag, " drops"}, int'(bus.drops), d);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int exp_id;

    initial begin
        bus.tick = 1'b0; bus.ack = 1'b0;
        bus1.tick = 1'b0; bus1.ack = 1'b0;
        // reset; ticks under reset are discarded
        add(1,0,0, 0,0,0,0,0);
        add(1,1,0, 0,0,0,0,0);
        // four ticks spaced three cycles -> first request
        add(0,1,0, 0,0,1,0,0); add(0,0,0, 0,0,1,0,0); add(0,0,0, 0,0,1,0,0);
        add(0,1,0, 0,0,2,0,0); add(0,0,0, 0,0,2,0,0); add(0,0,0, 0,0,2,0,0);
        add(0,1,0, 0,0,3,0,0); add(0,0,0, 0,0,3,0,0); add(0,0,0, 0,0,3,0,0);
        add(0,1,0, 1,1,0,0,0);
        add(0,0,0, 1,1,0,0,0);
        // ack releases; ack in idle ignored
        add(0,0,1, 0,1,0,0,0);
        add(0,0,1, 0,1,0,0,0);
        add(0,1,0, 0,1,1,0,0); add(0,1,0, 0,1,2,0,0); add(0,1,0, 0,1,3,0,0);
        add(0,1,0, 1,2,0,0,0);
        // overrun: fire without ack
        add(0,1,0, 1,2,1,0,0); add(0,1,0, 1,2,2,0,0); add(0,1,0, 1,2,3,0,0);
        add(0,1,0, 1,2,0,1,1);
        add(0,1,0, 1,2,1,1,1); add(0,1,0, 1,2,2,1,1); add(0,1,0, 1,2,3,1,1);
        add(0,1,0, 1,2,0,1,2);
        // ack coincident with fire: reissue, no drop
        add(0,1,0, 1,2,1,1,2); add(0,1,0, 1,2,2,1,2); add(0,1,0, 1,2,3,1,2);
        add(0,1,1, 1,3,0,1,2);
        add(0,0,0, 1,3,0,1,2);
        // reset in WAIT abandons request, overrides tick/ack
        add(1,1,1, 0,0,0,0,0);
        add(0,0,1, 0,0,0,0,0);
        add(0,1,1, 0,0,1,0,0);

        foreach (vecs[i]) begin
            rst = vecs[i].r; bus.tick = vecs[i].t; bus.ack = vecs[i].a;
            step();
            check_all($sformatf("vec%0d", i), vecs[i].req, int'(vecs[i].id), int'(vecs[i].ph),
                      vecs[i].ovr, int'(vecs[i].drops));
        end

        // drops saturation with tick held high
        rst = 1'b1; bus.tick = 1'b0; bus.ack = 1'b0;
        step();
        rst = 1'b0; bus.tick = 1'b1;
        for (int c = 1; c <= 260 * 4; c++) begin
            step();
            if (c == 40) check_all("sat40", 1'b1, 1, 0, 1'b1, 9);
        end
        check_all("sat_end", 1'b1, 1, 0, 1'b1, 255);
        rst = 1'b1;
        step();
        rst = 1'b0; bus.tick = 1'b0;
        check_all("sat_rst", 1'b0, 0, 0, 1'b0, 0);

        // K=1: every tick fires; ack whenever req is high
        rst1 = 1'b1;
        step();
        rst1 = 1'b0; bus1.tick = 1'b1;
        step();
        check("k1 first req", int'(bus1.req), 1);
        check("k1 first id", int'(bus1.req_id), 1);
        exp_id = 1;
        for (int c = 0; c < 260; c++) begin
            bus1.ack = bus1.req;
            step();
            exp_id = (exp_id + 1) % 256;
            check($sformatf("k1 req c%0d", c), int'(bus1.req), 1);
            check($sformatf("k1 id c%0d", c), int'(bus1.req_id), exp_id);
        end
        check("k1 phase", int'(bus1.phase), 0);
        check("k1 ovr", int'(bus1.ovr), 0);
        check("k1 drops", int'(bus1.drops), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
